uart_frame_assembler: RTL

- Parametrised successor to the fixed 8-byte UART word collector.
- Accepts a byte stream from the UART byte receiver, one single-cycle strobe per received byte, and packs NUM_BYTES bytes into one frame word.
- Packing order is selectable.
- Adds:
  - an inter-byte timeout that discards partial frames;
  - a one-deep output holding register with a valid/ready handshake;
  - sticky error flags.
- Sits between the UART byte receiver and the temperature/cipher datapath.

---
 rtl/uart_frame_assembler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_frame_assembler.sv
// Packs NUM_BYTES received UART bytes into one frame word, with an inter-byte timeout,
// a one-deep valid/ready output holding register and sticky timeout/overrun flags.
module uart_frame_assembler #(
    parameter int NUM_BYTES   = 8,
    parameter int LSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 208340
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst,
    input  logic                             byte_valid,
    input  logic [7:0]                       byte_data,
    input  logic                             frame_ready,
    input  logic                             clear_err,
    output logic                             frame_valid,
    output logic [NUM_BYTES*8-1:0]           frame_data,
    output logic [$clog2(NUM_BYTES+1)-1:0]   byte_cnt,
    output logic                             busy,
    output logic                             timeout_err,
    output logic                             overrun_err
);

    localparam int FW    = NUM_BYTES * 8;
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int TMO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [FW-1:0]    asm_q, asm_d, asm_placed;
    logic [FW-1:0]    frame_q, frame_d;
    logic             fv_q, fv_d;
    logic             terr_q, terr_d;
    logic             oerr_q, oerr_d;

    logic last_byte, complete, tmo_hit, take, overrun_set;
    int   slot_idx;

    assign last_byte   = (cnt_q == CNT_LAST);
    assign complete    = byte_valid && last_byte;
    assign tmo_hit     = (TIMEOUT_CYC != 0) && (state_q == COLLECT) && !byte_valid
                         && (tmo_q == TMO_LAST);
    assign take        = fv_q && frame_ready;
    assign overrun_set = complete && fv_q && !take;
    assign slot_idx    = (LSB_FIRST != 0) ? int'(cnt_q) : (NUM_BYTES - 1 - int'(cnt_q));

    // Assembly word with the incoming byte merged in; also the value loaded on completion.
    always_comb begin
        asm_placed = asm_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i == slot_idx) begin
                asm_placed[i*8 +: 8] = byte_data;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (byte_valid && !last_byte) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (byte_valid) begin
                    if (last_byte) begin
                        state_d = IDLE;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == COLLECT);
        frame_valid = fv_q;
        frame_data  = frame_q;
        byte_cnt    = cnt_q;
        timeout_err = terr_q;
        overrun_err = oerr_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q   <= '0;
            tmo_q   <= '0;
            asm_q   <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            terr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            asm_q   <= asm_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
            terr_q  <= terr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        asm_d   = asm_q;
        fv_d    = fv_q;
        frame_d = frame_q;

        // A byte on the expiry cycle takes priority over the timeout.
        if (byte_valid) begin
            tmo_d = '0;
            if (last_byte) begin
                cnt_d = '0;
                asm_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                asm_d = asm_placed;
            end
        end else if (tmo_hit) begin
            cnt_d = '0;
            asm_d = '0;
            tmo_d = '0;
        end else if ((state_q == COLLECT) && (TIMEOUT_CYC != 0)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (take) begin
            fv_d = 1'b0;
        end
        if (complete && (!fv_q || take)) begin
            fv_d    = 1'b1;
            frame_d = asm_placed;
        end

        // Set events win over a simultaneous clear.
        terr_d = tmo_hit | (terr_q & ~clear_err);
        oerr_d = overrun_set | (oerr_q & ~clear_err);
    end

endmodule
